// File: rtl/fp_add_sequencer.sv
// Multi-cycle bfloat16-style adder controller. One operand pair at a time goes
// through CMP, ALIGN, ADD and an iterative NORM. Rounding is by truncation.
module fp_add_sequencer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_x,
  input  logic [EXP_W+MAN_W:0]     in_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_sum,
  output logic                     busy
);

  localparam int MW = MAN_W + 1;  // mantissa with hidden one
  localparam int SW = MW + 1;     // sum with carry bit

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_t;

  typedef enum logic [2:0] {IDLE, CMP, ALIGN, ADD, NORM, DONE} state_t;

  state_t           state, state_nx;
  fp_t              x_q, y_q, p_q, q_q, res_q;
  logic [EXP_W-1:0] dist_q, exp_q;
  logic [MW-1:0]    pm_q, qm_q;
  logic [SW-1:0]    acc_q;
  logic             zero_hold;

  logic             x_zero, y_zero, any_zero, x_bigger, subtract;
  fp_t              bypass_res, norm_res;
  logic [MW-1:0]    qm_aligned;
  logic [SW-1:0]    add_res;
  logic             norm_finish;

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    x_zero      = (x_q.exp == '0);
    y_zero      = (y_q.exp == '0);
    any_zero    = x_zero | y_zero;
    x_bigger    = (x_q.exp > y_q.exp) || ((x_q.exp == y_q.exp) && (x_q.man >= y_q.man));
    bypass_res  = '0;
    if (!x_zero)      bypass_res = x_q;
    else if (!y_zero) bypass_res = y_q;

    qm_aligned = '0;
    if (dist_q < EXP_W'(MW)) qm_aligned = {1'b1, q_q.man} >> dist_q;

    subtract = (p_q.sign != q_q.sign);
    add_res  = subtract ? ({1'b0, pm_q} - {1'b0, qm_q})
                        : ({1'b0, pm_q} + {1'b0, qm_q});

    norm_finish   = 1'b1;
    norm_res      = '0;
    norm_res.sign = p_q.sign;
    if (acc_q[SW-1]) begin
      if (exp_q == ({EXP_W{1'b1}} - EXP_W'(1))) begin
        norm_res.exp = '1;
        norm_res.man = '0;
      end else begin
        norm_res.exp = exp_q + EXP_W'(1);
        norm_res.man = acc_q[MW-1:1];
      end
    end else if (acc_q[MW-1]) begin
      norm_res.exp = exp_q;
      norm_res.man = acc_q[MAN_W-1:0];
    end else if (exp_q == EXP_W'(1)) begin
      // Another left shift would reach exponent 0: underflow to +0.
      norm_res = '0;
    end else begin
      norm_finish = 1'b0;
    end

    state_nx = state;
    case (state)
      IDLE:  if (in_valid) state_nx = CMP;
      // The zero bypass holds CMP for one extra cycle before DONE.
      CMP:   state_nx = any_zero ? (zero_hold ? DONE : CMP) : ALIGN;
      ALIGN: state_nx = ADD;
      ADD:   state_nx = (add_res == '0) ? DONE : NORM;
      NORM:  if (norm_finish) state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: only control state and the result are reset; the datapath registers
  // are always written before they are read within an operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      res_q     <= '0;
      zero_hold <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          x_q       <= in_x;
          y_q       <= in_y;
          zero_hold <= 1'b0;
        end
        CMP: begin
          p_q    <= x_bigger ? x_q : y_q;
          q_q    <= x_bigger ? y_q : x_q;
          dist_q <= x_bigger ? (x_q.exp - y_q.exp) : (y_q.exp - x_q.exp);
          if (any_zero) begin
            zero_hold <= 1'b1;
            res_q     <= bypass_res;
          end
        end
        ALIGN: begin
          pm_q  <= {1'b1, p_q.man};
          qm_q  <= qm_aligned;
          exp_q <= p_q.exp;
        end
        ADD: begin
          acc_q <= add_res;
          if (add_res == '0) res_q <= '0;
        end
        NORM: begin
          if (norm_finish) begin
            res_q <= norm_res;
          end else begin
            acc_q <= acc_q << 1;
            exp_q <= exp_q - EXP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = res_q;

endmodule
